// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-producer writeback FIFO and arbiter feeding the regfile write port; optional WB_FORWARD_EN
module regfile_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_rd_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_ready_o,
  output logic [4:0]  rsW_o,
  output logic [31:0] dataW_o,
  output logic        RegWEn_o,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic        hazard1_o,
  output logic        hazard2_o
`ifdef WB_FORWARD_EN
  ,
  output logic [31:0] fwd1_o,
  output logic [31:0] fwd2_o
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [4:0]       r_fifo_rd   [DEPTH];
  logic [31:0]      r_fifo_data [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_mem_acc;
  logic             w_alu_acc;
  logic             w_push;
  logic             w_pop;
  logic [4:0]       w_push_rd;
  logic [31:0]      w_push_data;
  logic [DEPTH-1:0] w_entry_valid;
  logic [PW-1:0]    w_offset;
  logic             w_hit1;
  logic             w_hit2;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot early
  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign mem_ready_o = !w_full;
  assign alu_ready_o = !w_full && !mem_valid_i;

  assign w_mem_acc   = mem_valid_i && mem_ready_o;
  assign w_alu_acc   = alu_valid_i && alu_ready_o;
  assign w_push_rd   = mem_valid_i ? mem_rd_i : alu_rd_i;
  assign w_push_data = mem_valid_i ? mem_data_i : alu_data_i;
  // Writes to x0 complete the handshake but never occupy a slot
  assign w_push      = (w_mem_acc || w_alu_acc) && (w_push_rd != 5'd0);
  assign w_pop       = !w_empty;

  // Entry storage; occupancy is tracked by pointers so the array itself needs no reset
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= w_push_rd;
      r_fifo_data[r_wptr] <= w_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together leave the count unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: head of the FIFO is presented to the regfile for exactly one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      RegWEn_o <= 1'b0;
      rsW_o    <= '0;
      dataW_o  <= '0;
    end else if (w_pop) begin
      RegWEn_o <= 1'b1;
      rsW_o    <= r_fifo_rd[r_rptr];
      dataW_o  <= r_fifo_data[r_rptr];
    end else begin
      RegWEn_o <= 1'b0;
    end
  end

  // Slot i is live when its distance from the read pointer is below the count
  always_comb begin
    w_entry_valid = '0;
    w_offset      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_offset         = PW'(i) - r_rptr;
      w_entry_valid[i] = ({1'b0, w_offset} < r_count);
    end
  end

  // A read address is hazardous while any queued or in-flight write targets it
  always_comb begin
    w_hit1 = RegWEn_o && (rsW_o == rs1_i);
    w_hit2 = RegWEn_o && (rsW_o == rs2_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_valid[i] && (r_fifo_rd[i] == rs1_i)) w_hit1 = 1'b1;
      if (w_entry_valid[i] && (r_fifo_rd[i] == rs2_i)) w_hit2 = 1'b1;
    end
  end

  assign hazard1_o = (rs1_i != 5'd0) && w_hit1;
  assign hazard2_o = (rs2_i != 5'd0) && w_hit2;

`ifdef WB_FORWARD_EN
  logic [31:0]   w_fwd1;
  logic [31:0]   w_fwd2;
  logic [PW-1:0] w_fidx;

  // Walk oldest to youngest so the last match (youngest write) wins
  always_comb begin
    w_fwd1 = (RegWEn_o && (rsW_o == rs1_i)) ? dataW_o : 32'd0;
    w_fwd2 = (RegWEn_o && (rsW_o == rs2_i)) ? dataW_o : 32'd0;
    w_fidx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_fidx = r_rptr + PW'(k);
      if ((PW+1)'(k) < r_count) begin
        if (r_fifo_rd[w_fidx] == rs1_i) w_fwd1 = r_fifo_data[w_fidx];
        if (r_fifo_rd[w_fidx] == rs2_i) w_fwd2 = r_fifo_data[w_fidx];
      end
    end
  end

  assign fwd1_o = (rs1_i != 5'd0) ? w_fwd1 : 32'd0;
  assign fwd2_o = (rs2_i != 5'd0) ? w_fwd2 : 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized self-checking bench for regfile_wb_arbiter against a queue model
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        alu_valid_i = 1'b0;
  logic [4:0]  alu_rd_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        alu_ready_o;
  logic        mem_valid_i = 1'b0;
  logic [4:0]  mem_rd_i = '0;
  logic [31:0] mem_data_i = '0;
  logic        mem_ready_o;
  logic [4:0]  rsW_o;
  logic [31:0] dataW_o;
  logic        RegWEn_o;
  logic [4:0]  rs1_i = '0;
  logic [4:0]  rs2_i = '0;
  logic        hazard1_o;
  logic        hazard2_o;
`ifdef WB_FORWARD_EN
  logic [31:0] fwd1_o;
  logic [31:0] fwd2_o;
`endif

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .alu_valid_i (alu_valid_i),
    .alu_rd_i    (alu_rd_i),
    .alu_data_i  (alu_data_i),
    .alu_ready_o (alu_ready_o),
    .mem_valid_i (mem_valid_i),
    .mem_rd_i    (mem_rd_i),
    .mem_data_i  (mem_data_i),
    .mem_ready_o (mem_ready_o),
    .rsW_o       (rsW_o),
    .dataW_o     (dataW_o),
    .RegWEn_o    (RegWEn_o),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .hazard1_o   (hazard1_o),
    .hazard2_o   (hazard2_o)
`ifdef WB_FORWARD_EN
    ,
    .fwd1_o      (fwd1_o),
    .fwd2_o      (fwd2_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wb_t;

  wb_t         mq[$];
  logic        exp_en;
  logic [4:0]  exp_rd;
  logic [31:0] exp_d;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_haz(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    if (exp_en && exp_rd == rs) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].rd == rs) return mq[i].d;
    if (exp_en && exp_rd == rs) return exp_d;
    return 32'd0;
  endfunction

  task automatic check_outputs();
    logic full;
    full = (mq.size() == DEPTH);
    check_eq("mem_ready", mem_ready_o, !full);
    check_eq("alu_ready", alu_ready_o, !full && !mem_valid_i);
    check_eq("RegWEn", RegWEn_o, exp_en);
    check_eq("rsW", rsW_o, exp_rd);
    check_eq("dataW", dataW_o, exp_d);
    check_eq("hazard1", hazard1_o, model_haz(rs1_i));
    check_eq("hazard2", hazard2_o, model_haz(rs2_i));
`ifdef WB_FORWARD_EN
    check_eq("fwd1", fwd1_o, model_fwd(rs1_i));
    check_eq("fwd2", fwd2_o, model_fwd(rs2_i));
`endif
  endtask

  // One clock: check at negedge, advance the model at posedge, then update producers
  task automatic run_cycle(input bit rnd);
    logic full, m_acc, a_acc;
    wb_t  e;
    @(negedge clk_i);
    check_outputs();
    full  = (mq.size() == DEPTH);
    m_acc = mem_valid_i && !full;
    a_acc = alu_valid_i && !full && !mem_valid_i;
    @(posedge clk_i);
    if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_en = 1'b1;
      exp_rd = e.rd;
      exp_d  = e.d;
    end else begin
      exp_en = 1'b0;
    end
    if (m_acc && mem_rd_i != 5'd0) begin
      e.rd = mem_rd_i; e.d = mem_data_i; mq.push_back(e);
    end else if (a_acc && alu_rd_i != 5'd0) begin
      e.rd = alu_rd_i; e.d = alu_data_i; mq.push_back(e);
    end
    #1;
    if (m_acc) mem_valid_i = 1'b0;
    if (a_acc) alu_valid_i = 1'b0;
    if (rnd) begin
      if (!mem_valid_i && $urandom_range(0, 2) == 0) begin
        mem_valid_i = 1'b1;
        mem_rd_i    = 5'($urandom_range(0, 7));
        mem_data_i  = $urandom;
      end
      if (!alu_valid_i && $urandom_range(0, 1) == 0) begin
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'($urandom_range(0, 7));
        alu_data_i  = $urandom;
      end
      rs1_i = 5'($urandom_range(0, 7));
      rs2_i = 5'($urandom_range(0, 7));
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_en = 1'b0;
    exp_rd = '0;
    exp_d  = '0;
  endtask

  initial begin
    model_reset();

    // Reset state
    #12;
    check_eq("rst_RegWEn", RegWEn_o, 1'b0);
    check_eq("rst_rsW", rsW_o, 5'd0);
    check_eq("rst_dataW", dataW_o, 32'd0);
    check_eq("rst_alu_ready", alu_ready_o, 1'b1);
    check_eq("rst_mem_ready", mem_ready_o, 1'b1);
    for (int r = 0; r < 32; r++) begin
      rs1_i = 5'(r);
      rs2_i = 5'(31 - r);
      #1;
      check_eq("rst_hazard1", hazard1_o, 1'b0);
      check_eq("rst_hazard2", hazard2_o, 1'b0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single ALU write x5 = 0x214, watched via rs1
    rs1_i = 5'd5; rs2_i = 5'd0;
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'h214;
    run_cycle(0);
    run_cycle(0);
    check_eq("single_RegWEn", RegWEn_o, 1'b1);
    check_eq("single_rsW", rsW_o, 5'd5);
    check_eq("single_dataW", dataW_o, 32'h214);
    check_eq("single_haz_live", hazard1_o, 1'b1);
    run_cycle(0);
    check_eq("single_done", RegWEn_o, 1'b0);
    check_eq("single_haz_clear", hazard1_o, 1'b0);
    run_cycle(0);

    // Priority: mem wins, ALU waits one cycle
    alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h11;
    mem_valid_i = 1'b1; mem_rd_i = 5'd4; mem_data_i = 32'h22;
    rs1_i = 5'd3; rs2_i = 5'd4;
    #1;
    check_eq("prio_alu_blocked", alu_ready_o, 1'b0);
    run_cycle(0);
    run_cycle(0);
    check_eq("prio_first_rd", rsW_o, 5'd4);
    run_cycle(0);
    check_eq("prio_second_rd", rsW_o, 5'd3);
    run_cycle(0);

    // x0 write is accepted but never retired
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hFFFF;
    rs1_i = 5'd0;
    run_cycle(0);
    check_eq("x0_accepted", alu_valid_i, 1'b0);
    run_cycle(0);
    run_cycle(0);

    // Two writes to x7 back to back, watched via rs2
    rs2_i = 5'd7; rs1_i = 5'd7;
    alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'hA;
    run_cycle(0);
    alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'hB;
    for (int i = 0; i < 4; i++) run_cycle(0);

    // Randomized traffic from both producers
    for (int i = 0; i < 600; i++) run_cycle(1);
    while (mem_valid_i || alu_valid_i) run_cycle(0);
    for (int i = 0; i < 3; i++) run_cycle(0);

    // Asynchronous reset with writes in flight
    mem_valid_i = 1'b1; mem_rd_i = 5'd5; mem_data_i = 32'h55;
    alu_valid_i = 1'b1; alu_rd_i = 5'd6; alu_data_i = 32'h66;
    rs1_i = 5'd5; rs2_i = 5'd6;
    run_cycle(0);
    run_cycle(0);
    check_eq("pre_rst_haz1", hazard1_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_RegWEn", RegWEn_o, 1'b0);
    check_eq("midrst_alu_ready", alu_ready_o, 1'b1);
    check_eq("midrst_mem_ready", mem_ready_o, 1'b1);
    check_eq("midrst_hazard1", hazard1_o, 1'b0);
    check_eq("midrst_hazard2", hazard2_o, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) run_cycle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
